// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive framer.
// Takes the synchronized RX line and a 16x (OVERSAMPLE) baud tick, finds the
// start bit, samples every data bit at its centre (LSB first), checks the
// stop bit and reports the byte with a one-cycle oValid or oFrameErr pulse.
module uart_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 iClk,
  input  logic                 iReset,
  input  logic                 iCE,
  input  logic                 iRx,
  output logic [DATA_BITS-1:0] oDato,
  output logic                 oValid,
  output logic                 oFrameErr,
  output logic                 oBusy
);

  localparam int CNT_W  = $clog2(OVERSAMPLE);
  localparam int NBIT_W = $clog2(DATA_BITS);

  // Tick count at which each state takes its sample (mid start bit, bit centre)
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [NBIT_W-1:0] LAST_BIT  = NBIT_W'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : gBadDataBits
    $error("uart_rx_frame: DATA_BITS must be in 5..8");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : gBadOversample
    $error("uart_rx_frame: OVERSAMPLE must be even and at least 4");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state,     stateNext;
  logic [CNT_W-1:0]      cnt,       cntNext;
  logic [NBIT_W-1:0]     nbit,      nbitNext;
  logic [DATA_BITS-1:0]  sh,        shNext;
  logic                  armed,     armedNext;
  logic [DATA_BITS-1:0]  datoNext;
  logic                  validNext;
  logic                  errNext;

  // LSB-first deserialisation: new bit enters at the top and walks down, so
  // after DATA_BITS shifts the first received bit sits in bit 0.
  function automatic logic [DATA_BITS-1:0] shiftIn(
    input logic [DATA_BITS-1:0] cur,
    input logic                 b
  );
    return {b, cur[DATA_BITS-1:1]};
  endfunction

  // State register: FSM, counters, shift register and registered outputs
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state     <= IDLE;
      cnt       <= '0;
      nbit      <= '0;
      sh        <= '0;
      armed     <= 1'b0;
      oDato     <= '0;
      oValid    <= 1'b0;
      oFrameErr <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      nbit      <= nbitNext;
      sh        <= shNext;
      armed     <= armedNext;
      oDato     <= datoNext;
      oValid    <= validNext;
      oFrameErr <= errNext;
    end
  end

  // Next-state logic: everything advances only on an oversample tick, while
  // the strobes default low so they last exactly one iClk.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    nbitNext  = nbit;
    shNext    = sh;
    armedNext = armed;
    datoNext  = oDato;
    validNext = 1'b0;
    errNext   = 1'b0;

    if (iCE) begin
      case (state)
        IDLE: begin
          cntNext = '0;
          // A low line only starts a frame once the line has been seen high,
          // so a held break after a framing error is not decoded as data.
          if (armed && !iRx) begin
            stateNext = START;
          end else if (iRx) begin
            armedNext = 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cntNext = '0;
            if (iRx) begin
              stateNext = IDLE;
            end else begin
              stateNext = DATA;
              nbitNext  = '0;
            end
          end else begin
            cntNext = cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == FULL_LAST) begin
            cntNext = '0;
            shNext  = shiftIn(sh, iRx);
            if (nbit == LAST_BIT) begin
              stateNext = STOP;
              nbitNext  = '0;
            end else begin
              nbitNext = nbit + NBIT_W'(1);
            end
          end else begin
            cntNext = cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt == FULL_LAST) begin
            cntNext   = '0;
            // Leaving at the stop-bit centre lets a following start bit be
            // caught with no idle gap in between.
            stateNext = IDLE;
            if (iRx) begin
              datoNext  = sh;
              validNext = 1'b1;
              armedNext = 1'b1;
            end else begin
              errNext   = 1'b1;
              armedNext = 1'b0;
            end
          end else begin
            cntNext = cnt + CNT_W'(1);
          end
        end

        default: begin
          stateNext = IDLE;
          cntNext   = '0;
        end
      endcase
    end
  end

  // Output logic: busy follows the registered state only
  always_comb begin
    oBusy = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed bench for uart_rx_frame with hand-computed
// expectations; iCE is one iClk in four unless fastMode keeps it high.
module tb_uart_rx_frame;

  logic       iClk = 1'b0;
  logic       iReset;
  logic       iCE;
  logic       iRx;
  logic [7:0] oDato;
  logic       oValid;
  logic       oFrameErr;
  logic       oBusy;

  always #5 iClk = ~iClk;

  uart_rx_frame #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .iClk     (iClk),
    .iReset   (iReset),
    .iCE      (iCE),
    .iRx      (iRx),
    .oDato    (oDato),
    .oValid   (oValid),
    .oFrameErr(oFrameErr),
    .oBusy    (oBusy)
  );

  int         tickNum       = 0;
  int         detectTick    = 0;
  int         validCount    = 0;
  int         errCount      = 0;
  int         lastValidTick = -1;
  int         lastErrTick   = -1;
  int         overlapCount  = 0;
  int         wideCount     = 0;
  logic [7:0] lastDato      = 8'h00;
  logic       prevValid     = 1'b0;
  logic       prevErr       = 1'b0;
  bit         fastMode      = 1'b0;

  int nPass   = 0;
  int nFail   = 0;
  int nChecks = 0;

  // Strobe monitor, sampled on the falling edge
  always @(negedge iClk) begin
    if (oValid) begin
      validCount    <= validCount + 1;
      lastValidTick <= tickNum;
      lastDato      <= oDato;
    end
    if (oFrameErr) begin
      errCount    <= errCount + 1;
      lastErrTick <= tickNum;
    end
    if (oValid && oFrameErr) overlapCount <= overlapCount + 1;
    if ((oValid && prevValid) || (oFrameErr && prevErr)) wideCount <= wideCount + 1;
    prevValid <= oValid;
    prevErr   <= oFrameErr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One oversample tick carrying line level r
  task automatic tick(input logic r);
    iRx = r;
    iCE = 1'b1;
    @(posedge iClk);
    #1;
    tickNum++;
    if (!fastMode) begin
      iCE = 1'b0;
      repeat (3) @(posedge iClk);
      #1;
    end
  endtask

  task automatic idleClocks(input int n);
    iCE = 1'b0;
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic pulseReset();
    iReset = 1'b1;
    @(posedge iClk);
    #1;
    iReset = 1'b0;
  endtask

  // Full 10-bit frame, 16 ticks per bit; pauseAt>0 freezes iCE for 100 iClk
  // after that many ticks of the frame.
  task automatic sendFrame(input logic [7:0] d, input logic stopBit, input int pauseAt);
    for (int t = 0; t < 160; t++) begin
      logic b;
      if (t < 16)       b = 1'b0;
      else if (t < 144) b = d[(t - 16) / 16];
      else              b = stopBit;
      tick(b);
      if (t == 0) detectTick = tickNum;
      if (t + 1 == pauseAt) idleClocks(100);
    end
  endtask

  initial begin
    int v0;
    int e0;
    int t1;
    int busyTicks;

    iReset = 1'b1;
    iCE    = 1'b0;
    iRx    = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    iReset = 1'b0;

    check("rst_dato",  32'(oDato),     32'h00);
    check("rst_valid", 32'(oValid),    32'h0);
    check("rst_ferr",  32'(oFrameErr), 32'h0);
    check("rst_busy",  32'(oBusy),     32'h0);

    // Idle line, then 0x55
    repeat (32) tick(1'b1);
    check("idle_busy", 32'(oBusy), 32'h0);
    sendFrame(8'h55, 1'b1, 0);
    check("f55_vcnt",    32'(validCount), 32'd1);
    check("f55_ecnt",    32'(errCount),   32'd0);
    check("f55_data",    32'(lastDato),   32'h55);
    check("f55_latency", 32'(lastValidTick - detectTick), 32'd152);
    check("f55_dato",    32'(oDato),      32'h55);
    check("f55_busy",    32'(oBusy),      32'h0);

    // Back-to-back 0xA3, 0x00
    v0 = validCount;
    sendFrame(8'hA3, 1'b1, 0);
    t1 = lastValidTick;
    check("fA3_data", 32'(lastDato), 32'hA3);
    sendFrame(8'h00, 1'b1, 0);
    check("f00_data",    32'(lastDato), 32'h00);
    check("b2b_spacing", 32'(lastValidTick - t1), 32'd160);
    check("b2b_vcnt",    32'(validCount - v0),    32'd2);

    // Glitch: 4 low ticks is a false start
    repeat (8) tick(1'b1);
    v0 = validCount;
    e0 = errCount;
    repeat (4) tick(1'b0);
    check("glitch_busy4", 32'(oBusy), 32'h1);
    repeat (4) tick(1'b1);
    check("glitch_busy8", 32'(oBusy), 32'h1);
    tick(1'b1);
    check("glitch_busy9", 32'(oBusy), 32'h0);
    check("glitch_vcnt", 32'(validCount), 32'(v0));
    check("glitch_ecnt", 32'(errCount),   32'(e0));
    repeat (8) tick(1'b1);
    sendFrame(8'hC4, 1'b1, 0);
    check("fC4_data",    32'(lastDato),   32'hC4);
    check("fC4_vcnt",    32'(validCount), 32'(v0 + 1));
    check("fC4_latency", 32'(lastValidTick - detectTick), 32'd152);

    // Framing error, then a held break
    v0 = validCount;
    e0 = errCount;
    sendFrame(8'hFF, 1'b0, 0);
    check("ferr_ecnt",    32'(errCount),   32'(e0 + 1));
    check("ferr_vcnt",    32'(validCount), 32'(v0));
    check("ferr_dato",    32'(oDato),      32'hC4);
    check("ferr_latency", 32'(lastErrTick - detectTick), 32'd152);
    busyTicks = 0;
    for (int i = 0; i < 64; i++) begin
      tick(1'b0);
      if (oBusy) busyTicks++;
    end
    check("break_busy", 32'(busyTicks), 32'd0);
    repeat (16) tick(1'b1);
    sendFrame(8'h3C, 1'b1, 0);
    check("f3C_data", 32'(lastDato),   32'h3C);
    check("f3C_vcnt", 32'(validCount), 32'(v0 + 1));
    check("f3C_ecnt", 32'(errCount),   32'(e0 + 1));

    // Reset after 5 data bits of 0x0F
    v0 = validCount;
    e0 = errCount;
    for (int t = 0; t < 96; t++) begin
      logic [7:0] f;
      f = 8'h0F;
      tick((t < 16) ? 1'b0 : f[(t - 16) / 16]);
    end
    check("abort_busy_pre", 32'(oBusy), 32'h1);
    pulseReset();
    check("abort_dato", 32'(oDato), 32'h00);
    check("abort_busy", 32'(oBusy), 32'h0);
    busyTicks = 0;
    for (int i = 0; i < 32; i++) begin
      tick(1'b0);
      if (oBusy) busyTicks++;
    end
    check("abort_lowhold_busy", 32'(busyTicks),  32'd0);
    check("abort_vcnt",         32'(validCount), 32'(v0));
    check("abort_ecnt",         32'(errCount),   32'(e0));
    repeat (16) tick(1'b1);
    sendFrame(8'h81, 1'b1, 0);
    check("f81_data",    32'(lastDato), 32'h81);
    check("f81_latency", 32'(lastValidTick - detectTick), 32'd152);

    // iCE frozen for 100 iClk in the middle of bit 3
    v0 = validCount;
    repeat (8) tick(1'b1);
    sendFrame(8'h96, 1'b1, 72);
    check("f96_data",    32'(lastDato),   32'h96);
    check("f96_vcnt",    32'(validCount), 32'(v0 + 1));
    check("f96_latency", 32'(lastValidTick - detectTick), 32'd152);

    // iCE held high continuously
    v0 = validCount;
    fastMode = 1'b1;
    repeat (8) tick(1'b1);
    sendFrame(8'h5A, 1'b1, 0);
    repeat (4) tick(1'b1);
    fastMode = 1'b0;
    iCE = 1'b0;
    idleClocks(4);
    check("f5A_data",    32'(lastDato),   32'h5A);
    check("f5A_vcnt",    32'(validCount), 32'(v0 + 1));
    check("f5A_latency", 32'(lastValidTick - detectTick), 32'd152);

    check("strobe_overlap", 32'(overlapCount), 32'd0);
    check("strobe_width",   32'(wideCount),    32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
